divider: RTL

Sequential 8-bit unsigned restoring divider: the inverse companion of the team's shift-add multiplier, using the same board-level control style. The dividend is loaded from switches, the divisor is sampled from switches at Execute, and one quotient bit is resolved per two clocks. Quotient and remainder drive the same register/hex display path as the multiplier, so the two blocks are interchangeable on the top level.

---
 rtl/lab5_pkg.sv | 15 +
 rtl/divider_control.sv | 89 ++++++++
 rtl/hex_driver.sv | 32 +++
 rtl/divider.sv | 91 +++++++++
 4 files changed

// File: rtl/lab5_pkg.sv
// Shared definitions for the lab5 arithmetic blocks (divider and its control FSM).
package lab5_pkg;

  localparam int unsigned N_BITS = 8;
  localparam logic [6:0] SEG_BLANK_ZERO = 7'b1000000;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    SHIFT,
    SUB,
    DONE
  } div_state_t;

endpackage

// File: rtl/divider_control.sv
// Divider sequencer: Execute edge detect, iteration count and datapath strobes.
module divider_control
  import lab5_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic execute,
  input  logic clear_load,
  input  logic din_zero,
  output logic ld_q,
  output logic ld_d,
  output logic shift,
  output logic sub_en,
  output logic set_x,
  output logic busy
);

  localparam int unsigned CNT_W = $clog2(N_BITS);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             exec_q;
  logic             busy_q, busy_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exec_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exec_q  <= execute;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld_q    = 1'b0;
    ld_d    = 1'b0;
    shift   = 1'b0;
    sub_en  = 1'b0;
    set_x   = 1'b0;
    case (state_q)
      // A load in the same cycle as an Execute edge wins; the edge is lost.
      IDLE: begin
        if (clear_load) begin
          ld_q = 1'b1;
        end else if (execute && !exec_q) begin
          state_d = LATCH;
        end
      end
      LATCH: begin
        ld_d  = 1'b1;
        cnt_d = '0;
        if (din_zero) begin
          set_x   = 1'b1;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        shift   = 1'b1;
        state_d = SUB;
      end
      SUB: begin
        sub_en = 1'b1;
        if (cnt_q == CNT_W'(N_BITS - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = SHIFT;
        end
      end
      DONE: begin
        if (!execute) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == LATCH) || (state_d == SHIFT) || (state_d == SUB);
  end

  assign busy = busy_q;

endmodule

// File: rtl/hex_driver.sv
// Nibble to active-low seven-segment pattern, segment order gfedcba.
module hex_driver
  import lab5_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK_ZERO;
    case (nibble)
      4'h0: seg = SEG_BLANK_ZERO;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK_ZERO;
    endcase
  end

endmodule

// File: rtl/divider.sv
// Sequential 8-bit unsigned restoring divider with remainder/quotient hex display.
module divider
  import lab5_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset_h,
  input  logic              Execute_h,
  input  logic              ClearA_loadB_h,
  input  logic [N_BITS-1:0] Din,
  output logic [N_BITS-1:0] Aval,
  output logic [N_BITS-1:0] Bval,
  output logic [6:0]        AhexU,
  output logic [6:0]        AhexL,
  output logic [6:0]        BhexU,
  output logic [6:0]        BhexL,
  output logic              X,
  output logic              Busy
);

  localparam int unsigned W = N_BITS;

  logic [W:0]   r_q, r_d;
  logic [W-1:0] q_q, q_d;
  logic [W-1:0] d_q, d_d;
  logic         x_q, x_d;
  logic         ld_q, ld_d, shift, sub_en, set_x;

  divider_control u_control (
    .clk        (Clk),
    .rst        (Reset_h),
    .execute    (Execute_h),
    .clear_load (ClearA_loadB_h),
    .din_zero   (Din == '0),
    .ld_q       (ld_q),
    .ld_d       (ld_d),
    .shift      (shift),
    .sub_en     (sub_en),
    .set_x      (set_x),
    .busy       (Busy)
  );

  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      r_q <= '0;
      q_q <= '0;
      d_q <= '0;
      x_q <= 1'b0;
    end else begin
      r_q <= r_d;
      q_q <= q_d;
      d_q <= d_d;
      x_q <= x_d;
    end
  end

  // R stays below D before every shift, so the 9-bit R never overflows.
  always_comb begin
    r_d = r_q;
    q_d = q_q;
    d_d = d_q;
    x_d = x_q;
    if (ld_q) begin
      r_d = '0;
      q_d = Din;
      x_d = 1'b0;
    end
    if (ld_d) d_d = Din;
    if (set_x) begin
      q_d = '1;
      x_d = 1'b1;
    end
    if (shift) begin
      r_d = {r_q[W-1:0], q_q[W-1]};
      q_d = {q_q[W-2:0], 1'b0};
    end
    if (sub_en && (r_q >= {1'b0, d_q})) begin
      r_d    = r_q - {1'b0, d_q};
      q_d[0] = 1'b1;
    end
  end

  assign Aval = r_q[W-1:0];
  assign Bval = q_q;
  assign X    = x_q;

  hex_driver u_ahex_u (.nibble(Aval[7:4]), .seg(AhexU));
  hex_driver u_ahex_l (.nibble(Aval[3:0]), .seg(AhexL));
  hex_driver u_bhex_u (.nibble(Bval[7:4]), .seg(BhexU));
  hex_driver u_bhex_l (.nibble(Bval[3:0]), .seg(BhexL));

endmodule
